// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator for 1280x720 video.
// Flags are decoded from the next-state counters, so every output is registered and aligned.
module vga_timing_gen #(
  parameter int H_TOTAL      = 1650,
  parameter int V_TOTAL      = 750,
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720,
  parameter int H_SYNC_START = 1390,
  parameter int H_SYNC_LEN   = 41,
  parameter int V_SYNC_START = 725,
  parameter int V_SYNC_LEN   = 6,
  parameter int FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [10:0]       hcount,
  output logic [10:0]       vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              hblnk,
  output logic              vblnk,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLANK      = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLANK      = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_SYNC_START);
  localparam logic [10:0] H_SYNC_END   = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [10:0] V_SYNC_FIRST = 11'(V_SYNC_START);
  localparam logic [10:0] V_SYNC_END   = 11'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  logic              hWrap, vWrap;
  logic [10:0]       hcount_q, hcount_d;
  logic [10:0]       vcount_q, vcount_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              hblnk_q, hblnk_d;
  logic              vblnk_q, vblnk_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    hWrap       = (hcount_q == H_LAST);
    vWrap       = (vcount_q == V_LAST);
    hcount_d    = hWrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;
    if (hWrap) begin
      vcount_d = vWrap ? 11'd0 : vcount_q + 11'd1;
    end
    if (hWrap && vWrap) begin
      frame_cnt_d = frame_cnt_q + FCNT_ONE;
    end
    // Decoding the next-state counters keeps flags in the same cycle as the counts they describe.
    hsync_d       = (hcount_d >= H_SYNC_FIRST) && (hcount_d < H_SYNC_END);
    vsync_d       = (vcount_d >= V_SYNC_FIRST) && (vcount_d < V_SYNC_END);
    hblnk_d       = (hcount_d >= H_BLANK);
    vblnk_d       = (vcount_d >= V_BLANK);
    line_start_d  = hWrap;
    frame_start_d = hWrap && vWrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 1280x720 instance plus a shrunken 20x10 instance
// with a 2-bit frame counter so frame boundaries and counter wrap fit in a short run.
module tb_vga_timing_gen;

   logic clk;
   logic rst_n;

   logic [10:0] hcountA, vcountA;
   logic        hsyncA, vsyncA, hblnkA, vblnkA, lineStartA, frameStartA;
   logic [15:0] frameCntA;

   logic [10:0] hcountB, vcountB;
   logic        hsyncB, vsyncB, hblnkB, vblnkB, lineStartB, frameStartB;
   logic [1:0]  frameCntB;

   int vectorCount;
   int failCount;

   vga_timing_gen dutA (
      .clk(clk), .rst_n(rst_n),
      .hcount(hcountA), .vcount(vcountA),
      .hsync(hsyncA), .vsync(vsyncA), .hblnk(hblnkA), .vblnk(vblnkA),
      .line_start(lineStartA), .frame_start(frameStartA), .frame_cnt(frameCntA)
   );

   vga_timing_gen #(
      .H_TOTAL(20), .V_TOTAL(10), .H_ACTIVE(16), .V_ACTIVE(8),
      .H_SYNC_START(17), .H_SYNC_LEN(2), .V_SYNC_START(8), .V_SYNC_LEN(1),
      .FCNT_W(2)
   ) dutB (
      .clk(clk), .rst_n(rst_n),
      .hcount(hcountB), .vcount(vcountB),
      .hsync(hsyncB), .vsync(vsyncB), .hblnk(hblnkB), .vblnk(vblnkB),
      .line_start(lineStartB), .frame_start(frameStartB), .frame_cnt(frameCntB)
   );

   // Free-running pixel clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive reset on a falling edge, then let the given number of cycles go by.
   task automatic applyStimulus(input logic resetLevel, input int nCycles);
      @(negedge clk);
      rst_n = resetLevel;
      repeat (nCycles) @(negedge clk);
   endtask

   // Main sequence: edge e counts rising edges since reset release; samples are taken #1 after each edge.
   initial begin
      int hsCntA, hbCntA, lsCntA, vsCntA, vbCntA, fsCntA;
      int hsCntB, hbCntB, vsCntB, vbCntB, lsCntB, fsCntB, vMaxB;
      int fsIdx;
      logic [1:0] fcSeq [5];
      logic [1:0] fcExp [5];

      vectorCount = 0;
      failCount = 0;
      hsCntA = 0; hbCntA = 0; lsCntA = 0; vsCntA = 0; vbCntA = 0; fsCntA = 0;
      hsCntB = 0; hbCntB = 0; vsCntB = 0; vbCntB = 0; lsCntB = 0; fsCntB = 0; vMaxB = 0;
      fsIdx = 0;
      fcExp[0] = 2'd1; fcExp[1] = 2'd2; fcExp[2] = 2'd3; fcExp[3] = 2'd0; fcExp[4] = 2'd1;
      for (int i = 0; i < 5; i++) fcSeq[i] = 2'd0;

      rst_n = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("rst hcount", 32'(hcountA), 0);
      checkOutput("rst vcount", 32'(vcountA), 0);
      checkOutput("rst hsync", 32'(hsyncA), 0);
      checkOutput("rst vsync", 32'(vsyncA), 0);
      checkOutput("rst hblnk", 32'(hblnkA), 0);
      checkOutput("rst vblnk", 32'(vblnkA), 0);
      checkOutput("rst line_start", 32'(lineStartA), 0);
      checkOutput("rst frame_start", 32'(frameStartA), 0);
      checkOutput("rst frame_cnt", 32'(frameCntA), 0);
      checkOutput("rst B frame_cnt", 32'(frameCntB), 0);

      applyStimulus(1'b1, 0);

      for (int e = 1; e < 3300; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) begin
            checkOutput("first edge hcount", 32'(hcountA), 1);
            checkOutput("first edge vcount", 32'(vcountA), 0);
            checkOutput("first edge hblnk", 32'(hblnkA), 0);
            checkOutput("first edge line_start", 32'(lineStartA), 0);
            checkOutput("first edge B hcount", 32'(hcountB), 1);
         end
         if (e == 1279) checkOutput("hblnk before 1280", 32'(hblnkA), 0);
         if (e == 1280) checkOutput("hblnk at 1280", 32'(hblnkA), 1);
         if (e == 1389) checkOutput("hsync at 1389", 32'(hsyncA), 0);
         if (e == 1390) checkOutput("hsync at 1390", 32'(hsyncA), 1);
         if (e == 1430) checkOutput("hsync at 1430", 32'(hsyncA), 1);
         if (e == 1431) checkOutput("hsync at 1431", 32'(hsyncA), 0);
         if (e == 1649) begin
            checkOutput("line end hcount", 32'(hcountA), 1649);
            checkOutput("line end line_start", 32'(lineStartA), 0);
         end
         if (e == 1650) begin
            checkOutput("line wrap hcount", 32'(hcountA), 0);
            checkOutput("line wrap vcount", 32'(vcountA), 1);
            checkOutput("line wrap line_start", 32'(lineStartA), 1);
            checkOutput("line wrap frame_start", 32'(frameStartA), 0);
         end
         if (e == 1651) checkOutput("line_start drops", 32'(lineStartA), 0);
         if (e >= 1650) begin
            hsCntA += int'(hsyncA);
            hbCntA += int'(hblnkA);
            lsCntA += int'(lineStartA);
            vsCntA += int'(vsyncA);
            vbCntA += int'(vblnkA);
            fsCntA += int'(frameStartA);
         end

         if (e == 159) checkOutput("B vblnk before line 8", 32'(vblnkB), 0);
         if (e == 160) begin
            checkOutput("B vblnk at line 8", 32'(vblnkB), 1);
            checkOutput("B vsync at line 8", 32'(vsyncB), 1);
         end
         if (e == 180) begin
            checkOutput("B vsync at line 9", 32'(vsyncB), 0);
            checkOutput("B vblnk at line 9", 32'(vblnkB), 1);
         end
         if (e == 199) begin
            checkOutput("B pre-frame hcount", 32'(hcountB), 19);
            checkOutput("B pre-frame vcount", 32'(vcountB), 9);
            checkOutput("B pre-frame frame_cnt", 32'(frameCntB), 0);
            checkOutput("B pre-frame frame_start", 32'(frameStartB), 0);
         end
         if (e == 200) begin
            checkOutput("B frame hcount", 32'(hcountB), 0);
            checkOutput("B frame vcount", 32'(vcountB), 0);
            checkOutput("B frame frame_start", 32'(frameStartB), 1);
            checkOutput("B frame line_start", 32'(lineStartB), 1);
            checkOutput("B frame frame_cnt", 32'(frameCntB), 1);
         end
         if (e == 201) checkOutput("B frame_start drops", 32'(frameStartB), 0);
         if (e >= 200 && e < 400) begin
            hsCntB += int'(hsyncB);
            hbCntB += int'(hblnkB);
            vsCntB += int'(vsyncB);
            vbCntB += int'(vblnkB);
            lsCntB += int'(lineStartB);
            fsCntB += int'(frameStartB);
            if (int'(vcountB) > vMaxB) vMaxB = int'(vcountB);
         end
         if (frameStartB && e <= 1000 && fsIdx < 5) begin
            fcSeq[fsIdx] = frameCntB;
            fsIdx++;
         end
      end

      checkOutput("A line hsync width", 32'(hsCntA), 41);
      checkOutput("A line hblnk width", 32'(hbCntA), 370);
      checkOutput("A line line_start count", 32'(lsCntA), 1);
      checkOutput("A line vsync count", 32'(vsCntA), 0);
      checkOutput("A line vblnk count", 32'(vbCntA), 0);
      checkOutput("A line frame_start count", 32'(fsCntA), 0);
      checkOutput("B frame hsync cycles", 32'(hsCntB), 20);
      checkOutput("B frame hblnk cycles", 32'(hbCntB), 40);
      checkOutput("B frame vsync cycles", 32'(vsCntB), 20);
      checkOutput("B frame vblnk cycles", 32'(vbCntB), 40);
      checkOutput("B frame line_start count", 32'(lsCntB), 10);
      checkOutput("B frame frame_start count", 32'(fsCntB), 1);
      checkOutput("B frame vcount max", 32'(vMaxB), 9);
      checkOutput("B frame_start pulses in 5 frames", 32'(fsIdx), 5);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("B frame_cnt seq[%0d]", i), 32'(fcSeq[i]), 32'(fcExp[i]));
      end

      // Edge 3300 puts A at line 2; 1400 more edges lands inside hsync.
      repeat (1401) @(posedge clk);
      #1;
      checkOutput("pre-abort A hcount", 32'(hcountA), 1400);
      checkOutput("pre-abort A vcount", 32'(vcountA), 2);
      checkOutput("pre-abort A hsync", 32'(hsyncA), 1);
      checkOutput("pre-abort B frame_cnt", 32'(frameCntB), 3);
      checkOutput("pre-abort B vcount", 32'(vcountB), 5);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort A hcount", 32'(hcountA), 0);
      checkOutput("abort A vcount", 32'(vcountA), 0);
      checkOutput("abort A hsync", 32'(hsyncA), 0);
      checkOutput("abort A hblnk", 32'(hblnkA), 0);
      checkOutput("abort B frame_cnt", 32'(frameCntB), 0);
      checkOutput("abort B vcount", 32'(vcountB), 0);

      applyStimulus(1'b0, 3);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("restart A hcount", 32'(hcountA), 1);
      checkOutput("restart A vcount", 32'(vcountA), 0);
      checkOutput("restart A frame_cnt", 32'(frameCntA), 0);
      checkOutput("restart A frame_start", 32'(frameStartA), 0);
      checkOutput("restart B frame_cnt", 32'(frameCntB), 0);
      checkOutput("restart B hcount", 32'(hcountB), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule
